// File: rtl/lcd_inst_pkg.sv
// rtl/lcd_inst_pkg.sv - shared LCD constants, FSM state type and menu text ROM
// Purpose: LCD instruction/character codes, Avalon register addresses,
//          refresh FSM state encoding and the menu text ROM lookup.
// Ports:   none (package)
package lcd_inst_pkg;

  // Avalon register select: 0 = instruction register, 1 = data register
  localparam logic ADDR_CMD  = 1'b0;
  localparam logic ADDR_DATA = 1'b1;

  localparam logic [7:0] CMD_CLEAR  = 8'h01;
  localparam logic [7:0] CMD_LINE2  = 8'hC0;
  localparam logic [7:0] CHAR_STAR  = 8'h2A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Op counter wide enough for 2 + 2*16 operations
  localparam int               OP_W   = 6;
  localparam logic [OP_W-1:0]  OP_ONE = 6'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2
  } lcd_state_t;

  localparam logic [8*5-1:0] LINE0_PREFIX = "Item ";
  localparam logic [8*7-1:0] LINE1_PREFIX = "Option ";

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + {4'h0, v};
    return 8'h37 + {4'h0, v};
  endfunction

  // Text ROM: 16 items x 2 lines x 16 columns. Each line is a fixed prefix,
  // the item number as one hex digit, then space padding.
  function automatic logic [7:0] menu_char(input logic [3:0] idx,
                                           input logic       line,
                                           input logic [3:0] col);
    int c;
    c = int'(col);
    if (!line) begin
      if (c < 5) return LINE0_PREFIX[8*(4-c) +: 8];
      if (c == 5) return hex_char(idx);
    end else begin
      if (c < 7) return LINE1_PREFIX[8*(6-c) +: 8];
      if (c == 7) return hex_char(idx);
    end
    return CHAR_SPACE;
  endfunction

endpackage

// File: rtl/button_edge.sv
// rtl/button_edge.sv - raw button level to single-cycle press pulse
// Purpose: synchronises a raw active-high button level and emits a one-cycle
//          pulse on each rising edge.
// Ports:   clk, reset_n (sync, active-low); i_level raw level; o_pulse press pulse.
module button_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic i_level,
  output logic o_pulse
);

  logic r_sync;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= i_level;
      r_prev  <= r_sync;
      r_pulse <= r_sync & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/lcd_menu_writer.sv
// rtl/lcd_menu_writer.sv - button-driven menu with LCD refresh over Avalon-MM writes
// Purpose: left/right move a cursor through N_ITEMS entries, select commits the
//          entry; every change redraws the LCD with clear + line text writes.
// Ports:   clk, reset_n (sync, active-low); btn_left/right/select raw levels;
//          Avalon-MM master address/chipselect/byteenable/read/write/writedata,
//          waitrequest, readdata/response (ignored);
//          menu_index, menu_choice, choice_valid, busy status.
module lcd_menu_writer
  import lcd_inst_pkg::*;
#(
  parameter int N_ITEMS  = 6,
  parameter int N_CHARS  = 16,
  parameter int TWO_LINE = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_select,
  output logic                       address,
  output logic                       chipselect,
  output logic                       byteenable,
  output logic                       read,
  output logic                       write,
  output logic [7:0]                 writedata,
  input  logic                       waitrequest,
  input  logic [7:0]                 readdata,
  input  logic [1:0]                 response,
  output logic [$clog2(N_ITEMS)-1:0] menu_index,
  output logic [$clog2(N_ITEMS)-1:0] menu_choice,
  output logic                       choice_valid,
  output logic                       busy
);

  localparam int IDX_W = $clog2(N_ITEMS);
  localparam int N_OPS = (TWO_LINE != 0) ? (2 + 2*N_CHARS) : (1 + N_CHARS);

  localparam logic [OP_W-1:0]  LAST_OP    = OP_W'(N_OPS - 1);
  localparam logic [OP_W-1:0]  OP_L1_LAST = OP_W'(N_CHARS);
  localparam logic [OP_W-1:0]  OP_LINE2   = OP_W'(N_CHARS + 1);
  localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(N_ITEMS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  logic w_pulse_left;
  logic w_pulse_right;
  logic w_pulse_select;
  logic w_move;
  logic w_select_ok;
  logic w_nav_event;
  logic w_take;
  logic w_starred;
  logic w_unused;

  logic [OP_W-1:0] w_next_op;
  logic [3:0]      w_idx4;
  logic [3:0]      w_col;
  logic            w_next_addr;
  logic [7:0]      w_next_data;

  logic [IDX_W-1:0] r_index;
  logic [IDX_W-1:0] r_choice;
  logic             r_choice_valid;
  lcd_state_t       r_state;
  logic [OP_W-1:0]  r_op;
  logic             r_pending;
  logic             r_write;
  logic             r_address;
  logic [7:0]       r_writedata;
  logic             r_busy;

  button_edge u_btn_left (
    .clk     (clk),
    .reset_n (reset_n),
    .i_level (btn_left),
    .o_pulse (w_pulse_left)
  );

  button_edge u_btn_right (
    .clk     (clk),
    .reset_n (reset_n),
    .i_level (btn_right),
    .o_pulse (w_pulse_right)
  );

  button_edge u_btn_select (
    .clk     (clk),
    .reset_n (reset_n),
    .i_level (btn_select),
    .o_pulse (w_pulse_select)
  );

  // Opposing nav pulses cancel; select only counts when no nav pulse is present.
  assign w_move      = w_pulse_left ^ w_pulse_right;
  assign w_select_ok = w_pulse_select & ~w_pulse_left & ~w_pulse_right;
  assign w_nav_event = w_move | w_select_ok;
  assign w_unused    = ^{readdata, response};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_index        <= '0;
      r_choice       <= '0;
      r_choice_valid <= 1'b0;
    end else begin
      if (w_pulse_right && !w_pulse_left)
        r_index <= (r_index == IDX_MAX) ? '0 : r_index + IDX_ONE;
      else if (w_pulse_left && !w_pulse_right)
        r_index <= (r_index == '0) ? IDX_MAX : r_index - IDX_ONE;
      if (w_select_ok) begin
        r_choice       <= r_index;
        r_choice_valid <= 1'b1;
      end
    end
  end

  // A pending refresh is consumed whenever the FSM is between writes.
  assign w_take    = r_pending && (r_state != S_WRITE);
  assign w_idx4    = 4'(r_index);
  assign w_starred = r_choice_valid && (r_index == r_choice);

  // Op to launch next: from GAP it is op+1 unless a refresh restarts at op 0.
  always_comb begin
    w_next_op = '0;
    if (r_state == S_GAP && !r_pending) w_next_op = r_op + OP_ONE;
  end

  always_comb begin
    w_next_addr = ADDR_CMD;
    w_next_data = CMD_CLEAR;
    w_col       = '0;
    if (w_next_op == '0) begin
      w_next_addr = ADDR_CMD;
      w_next_data = CMD_CLEAR;
    end else if (w_next_op <= OP_L1_LAST) begin
      w_col       = 4'(w_next_op - OP_ONE);
      w_next_addr = ADDR_DATA;
      w_next_data = (w_col == 4'd0 && w_starred) ? CHAR_STAR
                                                 : menu_char(w_idx4, 1'b0, w_col);
    end else if (w_next_op == OP_LINE2) begin
      w_next_addr = ADDR_CMD;
      w_next_data = CMD_LINE2;
    end else begin
      w_col       = 4'(w_next_op - OP_LINE2 - OP_ONE);
      w_next_addr = ADDR_DATA;
      w_next_data = menu_char(w_idx4, 1'b1, w_col);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_pending   <= 1'b1;
      r_write     <= 1'b0;
      r_address   <= ADDR_CMD;
      r_writedata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_pending <= w_nav_event || (r_pending && !w_take);
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_state     <= S_WRITE;
            r_op        <= '0;
            r_write     <= 1'b1;
            r_address   <= w_next_addr;
            r_writedata <= w_next_data;
            r_busy      <= 1'b1;
          end
        end
        S_WRITE: begin
          if (!waitrequest) begin
            r_state     <= S_GAP;
            r_write     <= 1'b0;
            r_writedata <= '0;
          end
        end
        S_GAP: begin
          if (r_pending || r_op != LAST_OP) begin
            r_state     <= S_WRITE;
            r_op        <= w_next_op;
            r_write     <= 1'b1;
            r_address   <= w_next_addr;
            r_writedata <= w_next_data;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_write <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign address      = r_address;
  assign chipselect   = r_write;
  assign byteenable   = 1'b1;
  assign read         = 1'b0;
  assign write        = r_write;
  assign writedata    = r_writedata;
  assign menu_index   = r_index;
  assign menu_choice  = r_choice;
  assign choice_valid = r_choice_valid;
  assign busy         = r_busy;

endmodule
